bp_snd_cmd_sched: RTL and testbench

Sound-CPU command and interrupt scheduler for the Blue Print sound board. It sits between the main-CPU command write strobe and the sound Z80. It buffers command bytes in a small FIFO and issues one NMI per buffered command, then presents each byte to the AY1 port-B input until the sound CPU acknowledges it. It also generates the periodic maskable IRQ with interrupt-acknowledge clearing, replacing the single-register latch so back-to-back main-CPU writes are not lost.

---
 rtl/bp_snd_cmd_sched.sv | 216 +++++++++++++++++++++
 tb/tb_bp_snd_cmd_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_snd_cmd_sched.sv
// Sound-CPU command and interrupt scheduler for the Blue Print sound board.
//
// Main-CPU command bytes are buffered in a small FIFO. One NMI is issued to the
// sound Z80 per buffered command. The head byte is presented on cmd_out until
// the sound CPU reads AY1 port B (cmd_ack), which pops it. A free-running
// counter on cen raises the periodic maskable IRQ. The IRQ is cleared by the
// Z80 interrupt acknowledge cycle (M1 and IORQ both low).
//
// Ports:
//   clk_49m    in   master clock
//   reset      in   synchronous, active-high reset
//   cen        in   sound-CPU clock enable, one clk_49m cycle wide
//   cmd_in     in   command byte, valid while cmd_wr is high
//   cmd_wr     in   write strobe, level; each rising edge pushes one byte
//   cmd_ack    in   single-cycle pulse, sound CPU read of the command byte
//   n_m1       in   Z80 M1, active-low
//   n_iorq     in   Z80 IORQ, active-low
//   cmd_out    out  FIFO head, or the last popped byte when the FIFO is empty
//   n_nmi      out  sound Z80 NMI, active-low
//   n_irq      out  sound Z80 INT, active-low
//   fifo_count out  occupied FIFO entries
//   overflow   out  sticky, set when a byte is dropped because the FIFO is full
module bp_snd_cmd_sched #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned IRQ_PERIOD = 5208,
  parameter int unsigned NMI_WIDTH  = 2,
  parameter int unsigned NMI_GAP    = 4
) (
  input  logic                  clk_49m,
  input  logic                  reset,
  input  logic                  cen,
  input  logic [7:0]            cmd_in,
  input  logic                  cmd_wr,
  input  logic                  cmd_ack,
  input  logic                  n_m1,
  input  logic                  n_iorq,
  output logic [7:0]            cmd_out,
  output logic                  n_nmi,
  output logic                  n_irq,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow
);

  localparam int unsigned Depth   = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW    = DEPTH_LOG2;
  localparam int unsigned CntW    = DEPTH_LOG2 + 1;
  localparam int unsigned IrqW    = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
  localparam int unsigned TickMax = (NMI_WIDTH > NMI_GAP) ? NMI_WIDTH : NMI_GAP;
  // The tick counter only ever reaches TickMax-1.
  localparam int unsigned TickW   = (TickMax > 1) ? $clog2(TickMax) : 1;

  localparam logic [CntW-1:0]  FullCnt   = CntW'(Depth);
  localparam logic [IrqW-1:0]  IrqLast   = IrqW'(IRQ_PERIOD - 1);
  localparam logic [TickW-1:0] WidthLast = TickW'(NMI_WIDTH - 1);
  localparam logic [TickW-1:0] GapLast   = TickW'(NMI_GAP - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitPop, StGap} state_e;

  // Edge detectors
  logic cmd_wr_q;
  logic iack_prev_q;

  // FIFO
  logic [7:0]      mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      cmd_out_q;

  // NMI scheduler
  state_e          state_q;
  logic [TickW-1:0] tick_q;
  logic            n_nmi_q;

  // IRQ generator
  logic [IrqW-1:0] irq_cnt_q, irq_cnt_d;
  logic            n_irq_q, n_irq_d;

  logic push, pop, full, push_ok, iack, irq_wrap;

  always_comb begin
    push    = cmd_wr & ~cmd_wr_q;
    pop     = (state_q == StWaitPop) & cmd_ack;
    full    = (count_q == FullCnt);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    push_ok = push & (~full | pop);
    // Falling edge of (n_iorq | n_m1) marks the interrupt acknowledge cycle.
    iack    = iack_prev_q & ~(n_iorq | n_m1);
    irq_wrap = cen & (irq_cnt_q == IrqLast);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~push_ok);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    irq_cnt_d = irq_cnt_q;
    n_irq_d   = n_irq_q;
    if (cen) begin
      irq_cnt_d = irq_wrap ? '0 : irq_cnt_q + IrqW'(1);
    end
    if (iack) begin
      n_irq_d = 1'b1;
    end
    // Set after clear so a coincident wrap wins over the acknowledge.
    if (irq_wrap) begin
      n_irq_d = 1'b0;
    end
  end

  // Storage array carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_49m) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      cmd_wr_q    <= 1'b0;
      iack_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cmd_out_q   <= 8'h00;
      irq_cnt_q   <= '0;
      n_irq_q     <= 1'b1;
    end else begin
      cmd_wr_q    <= cmd_wr;
      iack_prev_q <= n_iorq | n_m1;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      irq_cnt_q   <= irq_cnt_d;
      n_irq_q     <= n_irq_d;
      // Holds the last popped byte once the FIFO drains, like the old latch.
      if (count_q != '0) begin
        cmd_out_q <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      n_nmi_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cen && (count_q != '0)) begin
            state_q <= StAssert;
            tick_q  <= '0;
            n_nmi_q <= 1'b0;
          end
        end
        StAssert: begin
          if (cen) begin
            if (tick_q == WidthLast) begin
              state_q <= StWaitPop;
              tick_q  <= '0;
              n_nmi_q <= 1'b1;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
        end
        StWaitPop: begin
          if (cmd_ack) begin
            state_q <= StGap;
            tick_q  <= '0;
          end
        end
        StGap: begin
          if (cen) begin
            if (tick_q == GapLast) begin
              state_q <= StIdle;
              tick_q  <= '0;
            end else begin
              tick_q <= tick_q + TickW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          tick_q  <= '0;
          n_nmi_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_out    = cmd_out_q;
  assign n_nmi      = n_nmi_q;
  assign n_irq      = n_irq_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bp_snd_cmd_sched.sv
// Bench for bp_snd_cmd_sched: push table, delivery scoreboard, IRQ and reset corners.
module tb_bp_snd_cmd_sched;

  localparam int unsigned IrqPeriod = 40;
  localparam int unsigned NmiWidth  = 2;
  localparam int unsigned NmiGap    = 4;
  localparam int unsigned CenDiv    = 4;

  logic       clk_49m = 1'b0;
  logic       reset   = 1'b1;
  logic       cen     = 1'b0;
  logic [7:0] cmd_in  = 8'h00;
  logic       cmd_wr  = 1'b0;
  logic       cmd_ack = 1'b0;
  logic       n_m1    = 1'b1;
  logic       n_iorq  = 1'b1;
  logic [7:0] cmd_out;
  logic       n_nmi;
  logic       n_irq;
  logic [2:0] fifo_count;
  logic       overflow;

  always #5 clk_49m = ~clk_49m;

  bp_snd_cmd_sched #(
    .DEPTH_LOG2 (2),
    .IRQ_PERIOD (IrqPeriod),
    .NMI_WIDTH  (NmiWidth),
    .NMI_GAP    (NmiGap)
  ) dut (
    .clk_49m    (clk_49m),
    .reset      (reset),
    .cen        (cen),
    .cmd_in     (cmd_in),
    .cmd_wr     (cmd_wr),
    .cmd_ack    (cmd_ack),
    .n_m1       (n_m1),
    .n_iorq     (n_iorq),
    .cmd_out    (cmd_out),
    .n_nmi      (n_nmi),
    .n_irq      (n_irq),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned cen_ticks = 0;
  int unsigned fall_tick = 0;
  int unsigned ack_tick  = 0;
  int          nmi_falls = 0;
  int          nmi_rises = 0;
  int          irq_falls = 0;
  bit          gap_armed = 1'b0;
  logic        prev_nmi  = 1'b1;
  logic        prev_irq  = 1'b1;
  logic [7:0]  sb [$];

  typedef struct {
    logic [7:0]  data;
    int unsigned exp_count;
    logic        exp_ovf;
    bit          accepted;
  } push_vec_t;

  push_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: DUT samples at posedge, outputs observed 1ns later, cen set for next edge.
  task automatic step();
    logic [7:0] exp_b;
    @(posedge clk_49m);
    if (cen && !reset) cen_ticks++;
    #1;
    if (!reset) begin
      if (prev_nmi && !n_nmi) begin
        nmi_falls++;
        fall_tick = cen_ticks;
        if (gap_armed) begin
          chk("nmi_gap", fall_tick - ack_tick, NmiGap + 1);
          gap_armed = 1'b0;
        end
      end
      if (!prev_nmi && n_nmi) begin
        nmi_rises++;
        chk("nmi_width", cen_ticks - fall_tick, NmiWidth);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL nmi_unexpected: cmd_out 0x%0h with nothing queued", cmd_out);
        end else begin
          exp_b = sb.pop_front();
          chk("cmd_out_at_nmi", {24'h0, cmd_out}, {24'h0, exp_b});
        end
      end
      if (prev_irq && !n_irq) begin
        irq_falls++;
        chk("irq_phase", cen_ticks % IrqPeriod, 0);
      end
      prev_nmi = n_nmi;
      prev_irq = n_irq;
    end
    cyc++;
    cen = ((cyc % CenDiv) == 0);
  endtask

  task automatic clear_tb_state();
    cen_ticks = 0;
    nmi_falls = 0;
    nmi_rises = 0;
    irq_falls = 0;
    gap_armed = 1'b0;
    prev_nmi  = 1'b1;
    prev_irq  = 1'b1;
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_tb_state();
  endtask

  task automatic wait_cens(input int unsigned n);
    int unsigned target;
    target = cen_ticks + n;
    while (cen_ticks < target) step();
  endtask

  task automatic wait_nmi_rises(input int target);
    for (int i = 0; i < 2000 && nmi_rises < target; i++) step();
    chk("nmi_rise_wait", nmi_rises, target);
  endtask

  task automatic push_byte(input logic [7:0] d);
    cmd_in = d;
    cmd_wr = 1'b1;
    sb.push_back(d);
    step();
    cmd_wr = 1'b0;
    step();
  endtask

  task automatic do_ack(input bit more);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    ack_tick  = cen_ticks;
    gap_armed = more;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h01, 1, 1'b0, 1'b1};
    vecs[1] = '{8'h02, 2, 1'b0, 1'b1};
    vecs[2] = '{8'h03, 3, 1'b0, 1'b1};
    vecs[3] = '{8'h04, 4, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 4, 1'b1, 1'b0};

    // Reset values and idle IRQ behaviour
    do_reset();
    chk("rst_cmd_out", {24'h0, cmd_out}, 32'h00);
    chk("rst_n_nmi", {31'h0, n_nmi}, 1);
    chk("rst_n_irq", {31'h0, n_irq}, 1);
    chk("rst_count", {29'h0, fifo_count}, 0);
    chk("rst_overflow", {31'h0, overflow}, 0);
    wait_cens(3 * IrqPeriod);
    chk("idle_irq_falls", irq_falls, 1);
    chk("idle_n_irq", {31'h0, n_irq}, 0);
    chk("idle_nmi_falls", nmi_falls, 0);
    chk("idle_cmd_out", {24'h0, cmd_out}, 32'h00);

    // M1 alone is not an acknowledge
    n_m1 = 1'b0;
    step();
    step();
    chk("irq_m1_only", {31'h0, n_irq}, 0);
    n_m1 = 1'b1;
    step();
    // Full acknowledge, held for 4 clocks
    n_m1   = 1'b0;
    n_iorq = 1'b0;
    step();
    chk("irq_ack", {31'h0, n_irq}, 1);
    repeat (3) step();
    n_m1   = 1'b1;
    n_iorq = 1'b1;
    step();
    chk("irq_ack_hold", {31'h0, n_irq}, 1);
    // Acknowledge coincident with the wrapping cen
    for (int i = 0; i < 1000 && !(cen && ((cen_ticks + 1) % IrqPeriod == 0)); i++) step();
    n_m1   = 1'b0;
    n_iorq = 1'b0;
    step();
    chk("irq_set_wins", {31'h0, n_irq}, 0);
    chk("irq_falls_2", irq_falls, 2);
    n_m1   = 1'b1;
    n_iorq = 1'b1;
    wait_cens(3);
    chk("irq_stays_low", {31'h0, n_irq}, 0);
    n_m1   = 1'b0;
    n_iorq = 1'b0;
    step();
    chk("irq_ack_2", {31'h0, n_irq}, 1);
    n_m1   = 1'b1;
    n_iorq = 1'b1;
    step();

    // Single command
    do_reset();
    push_byte(8'h3A);
    chk("single_count", {29'h0, fifo_count}, 1);
    wait_nmi_rises(1);
    wait_cens(10);
    do_ack(1'b0);
    chk("single_pop_count", {29'h0, fifo_count}, 0);
    wait_cens(10);
    chk("single_cmd_hold", {24'h0, cmd_out}, 32'h3A);
    chk("single_nmi_falls", nmi_falls, 1);

    // Back-to-back pushes with overflow, then drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_in = vecs[i].data;
      cmd_wr = 1'b1;
      if (vecs[i].accepted) sb.push_back(vecs[i].data);
      step();
      chk($sformatf("tbl_count_%0d", i), {29'h0, fifo_count}, vecs[i].exp_count);
      chk($sformatf("tbl_ovf_%0d", i), {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
      cmd_wr = 1'b0;
      step();
    end
    wait_cens(10);
    chk("tbl_one_nmi", nmi_falls, 1);
    for (int i = 0; i < 4; i++) begin
      wait_nmi_rises(i + 1);
      wait_cens(6);
      do_ack(i < 3);
      chk($sformatf("drain_count_%0d", i), {29'h0, fifo_count}, 3 - i);
    end
    wait_cens(20);
    chk("drain_nmi_falls", nmi_falls, 4);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_ovf_sticky", {31'h0, overflow}, 1);
    chk("drain_cmd_out", {24'h0, cmd_out}, 32'h04);

    // Long write strobe pushes once
    do_reset();
    cmd_in = 8'h5C;
    cmd_wr = 1'b1;
    sb.push_back(8'h5C);
    repeat (100) step();
    cmd_wr = 1'b0;
    step();
    chk("long_wr_count", {29'h0, fifo_count}, 1);
    chk("long_wr_ovf", {31'h0, overflow}, 0);
    chk("long_wr_nmis", nmi_falls, 1);

    // Full FIFO: push coincident with pop
    do_reset();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    push_byte(8'hA4);
    chk("full_count", {29'h0, fifo_count}, 4);
    wait_nmi_rises(1);
    cmd_in  = 8'h77;
    cmd_wr  = 1'b1;
    cmd_ack = 1'b1;
    sb.push_back(8'h77);
    step();
    cmd_wr    = 1'b0;
    cmd_ack   = 1'b0;
    ack_tick  = cen_ticks;
    gap_armed = 1'b1;
    chk("pushpop_count", {29'h0, fifo_count}, 4);
    chk("pushpop_ovf", {31'h0, overflow}, 0);
    for (int i = 0; i < 4; i++) begin
      wait_nmi_rises(i + 2);
      wait_cens(6);
      do_ack(i < 3);
      chk($sformatf("pushpop_drain_%0d", i), {29'h0, fifo_count}, 3 - i);
    end
    wait_cens(20);
    chk("pushpop_nmi_falls", nmi_falls, 5);
    chk("pushpop_sb_empty", sb.size(), 0);
    chk("pushpop_last", {24'h0, cmd_out}, 32'h77);

    // Reset during an NMI pulse
    do_reset();
    push_byte(8'hB1);
    push_byte(8'hB2);
    push_byte(8'hB3);
    chk("mid_count", {29'h0, fifo_count}, 3);
    for (int i = 0; i < 200 && n_nmi !== 1'b0; i++) step();
    chk("mid_nmi_low", {31'h0, n_nmi}, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_n_nmi", {31'h0, n_nmi}, 1);
    chk("mid_rst_count", {29'h0, fifo_count}, 0);
    chk("mid_rst_cmd_out", {24'h0, cmd_out}, 32'h00);
    chk("mid_rst_ovf", {31'h0, overflow}, 0);
    step();
    reset = 1'b0;
    clear_tb_state();
    wait_cens(10);
    chk("mid_no_nmi", nmi_falls, 0);
    chk("mid_n_nmi_high", {31'h0, n_nmi}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
